debug_mem_bridge: RTL and testbench

DEBUG_MEM_BRIDGE -- requirements
Module: debug_mem_bridge

---
 rtl/dbg_mem_pkg.sv | 28 ++
 rtl/dbg_rd_lat_ctr.sv | 36 +++
 rtl/debug_mem_bridge.sv | 210 +++++++++++++++++++++
 tb/tb_debug_mem_bridge.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dbg_mem_pkg.sv
// Shared types and constants for the debug memory bridge.
package dbg_mem_pkg;

  localparam int DATA_W     = 32;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;
  localparam int CTR_W      = 2;

  typedef enum logic [2:0] {
    ST_CPU      = 3'd0,
    ST_DBG_IDLE = 3'd1,
    ST_DBG_RD   = 3'd2,
    ST_DBG_WR   = 3'd3,
    ST_DBG_VFY  = 3'd4
  } state_t;

  // Out-of-range latencies are pinned to the nearest legal value.
  function automatic int clamp_lat(input int lat);
    if (lat < RD_LAT_MIN) begin
      return RD_LAT_MIN;
    end else if (lat > RD_LAT_MAX) begin
      return RD_LAT_MAX;
    end else begin
      return lat;
    end
  endfunction

endpackage

// File: rtl/dbg_rd_lat_ctr.sv
// Read-latency down-counter: load starts a wait of LAT cycles, o_done marks
// the last one (the cycle in which memory read data is valid).
module dbg_rd_lat_ctr
  import dbg_mem_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_load,
  output logic o_done
);

  localparam logic [CTR_W-1:0] LOAD_V = CTR_W'(clamp_lat(LAT));

  logic [CTR_W-1:0] r_cnt;

  // Clear has priority over load; otherwise count down to zero and hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CTR_W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CTR_W{1'b0}};
    end else if (i_load) begin
      r_cnt <= LOAD_V;
    end else if (r_cnt != {CTR_W{1'b0}}) begin
      r_cnt <= r_cnt - CTR_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_done = (r_cnt == CTR_W'(1));

endmodule

// File: rtl/debug_mem_bridge.sv
// Arbitrates a single-port memory between the CPU and a debug monitor.
// Optional write read-back check: define DEBUG_MEM_BRIDGE_WR_VERIFY_EN.
module debug_mem_bridge
  import dbg_mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       dbg_addr,
  input  logic [31:0]       dbg_wdata,
  input  logic              dbg_ce,
  input  logic              dbg_we,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_rdata_ready,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_en,
  input  logic              cpu_we,
  output logic [31:0]       cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_en,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  output logic              dbg_busy,
  output logic              wr_verify_err
);

  state_t              r_state;
  logic                r_ce_d;
  logic                r_ready;
  logic                r_busy;
  logic                r_dmem_en;
  logic                r_dmem_we;
  logic [ADDR_W-1:0]   r_op_addr;
  logic [ADDR_W-1:0]   r_lat_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
`ifdef DEBUG_MEM_BRIDGE_WR_VERIFY_EN
  logic                r_vfy_err;
`endif

  logic [ADDR_W-1:0]   w_word;
  logic                w_ce_rise;
  logic                w_cpu_mode;
  logic                w_in_rd;
  logic                w_abort_rd;
  logic                w_ctr_done;
  logic                w_rd_done;
  logic                w_unused;

  assign w_word     = dbg_addr[ADDR_W+1:2];
  assign w_ce_rise  = dbg_ce & ~r_ce_d;
  assign w_cpu_mode = (r_state == ST_CPU);
  assign w_in_rd    = (r_state == ST_DBG_RD) | (r_state == ST_DBG_VFY);
  assign w_abort_rd = ~dbg_ce | ((r_state == ST_DBG_RD) & dbg_we);
  assign w_rd_done  = w_in_rd & ~r_dmem_en & w_ctr_done;
  assign w_unused   = ^{dbg_addr[31:ADDR_W+2], dbg_addr[1:0],
                        cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

  dbg_rd_lat_ctr #(
    .LAT    (RD_LAT)
  ) u_lat_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (~w_in_rd | w_abort_rd),
    .i_load (w_in_rd & r_dmem_en),
    .o_done (w_ctr_done)
  );

  // Debug sequencer; r_dmem_en/r_dmem_we are one-cycle pulses into memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_CPU;
      r_ce_d     <= 1'b0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_dmem_en  <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_op_addr  <= {ADDR_W{1'b0}};
      r_lat_addr <= {ADDR_W{1'b0}};
      r_wdata    <= {DATA_W{1'b0}};
      r_rdata    <= {DATA_W{1'b0}};
`ifdef DEBUG_MEM_BRIDGE_WR_VERIFY_EN
      r_vfy_err  <= 1'b0;
`endif
    end else begin
      r_ce_d    <= dbg_ce;
      r_dmem_en <= 1'b0;
      r_dmem_we <= 1'b0;
      case (r_state)
        ST_CPU: begin
          r_ready <= 1'b0;
          if (w_ce_rise) begin
            r_state   <= ST_DBG_RD;
            r_op_addr <= w_word;
            r_dmem_en <= 1'b1;
            r_busy    <= 1'b1;
`ifdef DEBUG_MEM_BRIDGE_WR_VERIFY_EN
            r_vfy_err <= 1'b0;
`endif
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_DBG_IDLE: begin
          if (!dbg_ce) begin
            r_state <= ST_CPU;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
          end else if (dbg_we) begin
            r_state   <= ST_DBG_WR;
            r_op_addr <= w_word;
            r_wdata   <= dbg_wdata;
            r_dmem_en <= 1'b1;
            r_dmem_we <= 1'b1;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
          end else if (w_word != r_lat_addr) begin
            r_state   <= ST_DBG_RD;
            r_op_addr <= w_word;
            r_dmem_en <= 1'b1;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
          end else begin
            r_state <= ST_DBG_IDLE;
          end
        end
        ST_DBG_RD: begin
          if (!dbg_ce) begin
            r_state <= ST_CPU;
            r_busy  <= 1'b0;
          end else if (dbg_we) begin
            r_state   <= ST_DBG_WR;
            r_op_addr <= w_word;
            r_wdata   <= dbg_wdata;
            r_dmem_en <= 1'b1;
            r_dmem_we <= 1'b1;
          end else if (w_rd_done) begin
            r_state    <= ST_DBG_IDLE;
            r_rdata    <= mem_rdata;
            r_lat_addr <= r_op_addr;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_state <= ST_DBG_RD;
          end
        end
        ST_DBG_WR: begin
          if (!dbg_ce) begin
            r_state <= ST_CPU;
            r_busy  <= 1'b0;
          end else begin
`ifdef DEBUG_MEM_BRIDGE_WR_VERIFY_EN
            r_state   <= ST_DBG_VFY;
`else
            r_state   <= ST_DBG_RD;
`endif
            r_dmem_en <= 1'b1;
          end
        end
`ifdef DEBUG_MEM_BRIDGE_WR_VERIFY_EN
        ST_DBG_VFY: begin
          if (!dbg_ce) begin
            r_state <= ST_CPU;
            r_busy  <= 1'b0;
          end else if (w_rd_done) begin
            r_state    <= ST_DBG_IDLE;
            r_rdata    <= mem_rdata;
            r_lat_addr <= r_op_addr;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            if (mem_rdata != r_wdata) begin
              r_vfy_err <= 1'b1;
            end else begin
              r_vfy_err <= r_vfy_err;
            end
          end else begin
            r_state <= ST_DBG_VFY;
          end
        end
`endif
        default: begin
          r_state <= ST_CPU;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Debug strobes are gated by dbg_ce so nothing is written after it falls.
  assign mem_addr  = w_cpu_mode ? cpu_addr[ADDR_W+1:2] : r_op_addr;
  assign mem_wdata = w_cpu_mode ? cpu_wdata : r_wdata;
  assign mem_en    = w_cpu_mode ? cpu_en : (r_dmem_en & dbg_ce);
  assign mem_we    = w_cpu_mode ? (cpu_en & cpu_we) : (r_dmem_we & dbg_ce);
  assign cpu_rdata = mem_rdata;

  assign dbg_rdata       = r_rdata;
  assign dbg_busy        = r_busy;
  assign dbg_rdata_ready = r_ready & dbg_ce & ~dbg_we & (w_word == r_lat_addr);
`ifdef DEBUG_MEM_BRIDGE_WR_VERIFY_EN
  assign wr_verify_err = r_vfy_err;
`else
  assign wr_verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_debug_mem_bridge.sv
// Directed bench for debug_mem_bridge with RD_LAT = 1 and a 1-cycle memory.
module tb_debug_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        dbg_ce, dbg_we, dbg_rdata_ready;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_en, cpu_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_en, mem_we;
  logic        dbg_busy, wr_verify_err;

  logic [31:0] mem [0:1023];
  logic [31:0] r_mrd;
  logic        stuck0 = 1'b0;
  int          n_we = 0;
  int          n_we0;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  debug_mem_bridge #(.ADDR_W(10), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ce(dbg_ce), .dbg_we(dbg_we),
    .dbg_rdata(dbg_rdata), .dbg_rdata_ready(dbg_rdata_ready),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_en(cpu_en), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .dbg_busy(dbg_busy), .wr_verify_err(wr_verify_err)
  );

  // Single-port synchronous memory; stuck0 forces stored bit 0 low.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[8]  <= 32'h1234_5678;
      mem[12] <= 32'hCAFE_F00D;
    end else begin
      if (mem_en && mem_we) mem[mem_addr] <= stuck0 ? (mem_wdata & 32'hFFFF_FFFE) : mem_wdata;
      if (mem_en) r_mrd <= mem[mem_addr];
    end
  end
  assign mem_rdata = r_mrd;

  always @(posedge clk) if (mem_we === 1'b1) n_we <= n_we + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0; dbg_ce = 1'b0; dbg_we = 1'b0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_en = 1'b0; cpu_we = 1'b0;
    #12;
    check_eq("rst_rdata", dbg_rdata, 32'h0);
    check_eq("rst_ready", {31'b0, dbg_rdata_ready}, 32'd0);
    check_eq("rst_busy", {31'b0, dbg_busy}, 32'd0);
    check_eq("rst_verr", {31'b0, wr_verify_err}, 32'd0);
    rst_n = 1'b1;
    step();

    // CPU passthrough write then read
    cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hA5A5_A5A5;
    #1;
    check_eq("cpu_maddr", {22'b0, mem_addr}, 32'd4);
    check_eq("cpu_mwe", {31'b0, mem_we}, 32'd1);
    check_eq("cpu_mwdata", mem_wdata, 32'hA5A5_A5A5);
    step();
    cpu_we = 1'b0;
    step();
    check_eq("cpu_rdata", cpu_rdata, 32'hA5A5_A5A5);
    cpu_en = 1'b0;

    // dbg_ce rise read of word 8
    dbg_addr = 32'h20; dbg_ce = 1'b1;
    step();
    check_eq("rd_busy", {31'b0, dbg_busy}, 32'd1);
    check_eq("rd_men", {31'b0, mem_en}, 32'd1);
    cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hFFFF_FFFF;
    #1;
    check_eq("rd_cpu_blk_we", {31'b0, mem_we}, 32'd0);
    check_eq("rd_maddr", {22'b0, mem_addr}, 32'd8);
    cpu_en = 1'b0; cpu_we = 1'b0;
    step();
    check_eq("rd_ready_c1", {31'b0, dbg_rdata_ready}, 32'd0);
    step();
    check_eq("rd_ready_c2", {31'b0, dbg_rdata_ready}, 32'd1);
    check_eq("rd_data", dbg_rdata, 32'h1234_5678);
    check_eq("rd_idle_busy", {31'b0, dbg_busy}, 32'd0);
    dbg_addr = 32'h24; #1;
    check_eq("rdy_addr_chg", {31'b0, dbg_rdata_ready}, 32'd0);
    dbg_addr = 32'h1020; #1;
    check_eq("rdy_addr_wrap", {31'b0, dbg_rdata_ready}, 32'd1);
    dbg_addr = 32'h20;

    // debug write from DBG_IDLE
    n_we0 = n_we;
    dbg_we = 1'b1; dbg_wdata = 32'hDEAD_BEEF; #1;
    check_eq("wr_rdy_drop", {31'b0, dbg_rdata_ready}, 32'd0);
    step();
    dbg_we = 1'b0; #1;
    check_eq("wr_mwe", {31'b0, mem_we}, 32'd1);
    check_eq("wr_mwdata", mem_wdata, 32'hDEAD_BEEF);
    check_eq("wr_maddr", {22'b0, mem_addr}, 32'd8);
    step(); step(); step();
    check_eq("wr_ready", {31'b0, dbg_rdata_ready}, 32'd1);
    check_eq("wr_rdata", dbg_rdata, 32'hDEAD_BEEF);
    check_eq("wr_verr", {31'b0, wr_verify_err}, 32'd0);
    check_eq("wr_we_count", 32'(n_we - n_we0), 32'd1);

    // dbg_we aborts a read in its capture cycle
    dbg_addr = 32'h30;
    step(); step();
    dbg_we = 1'b1; dbg_wdata = 32'h1111_2222;
    step();
    dbg_we = 1'b0; #1;
    check_eq("abt_no_capture", dbg_rdata, 32'hDEAD_BEEF);
    check_eq("abt_mwe", {31'b0, mem_we}, 32'd1);
    check_eq("abt_mwdata", mem_wdata, 32'h1111_2222);
    check_eq("abt_maddr", {22'b0, mem_addr}, 32'd12);
    step(); step(); step();
    check_eq("abt_rdata", dbg_rdata, 32'h1111_2222);
    check_eq("abt_ready", {31'b0, dbg_rdata_ready}, 32'd1);

    // dbg_ce dropped during DBG_WR
    dbg_we = 1'b1; dbg_wdata = 32'h55AA_55AA;
    step();
    dbg_we = 1'b0; dbg_ce = 1'b0; #1;
    check_eq("cedrop_mwe", {31'b0, mem_we}, 32'd0);
    n_we0 = n_we;
    step();
    check_eq("cedrop_busy", {31'b0, dbg_busy}, 32'd0);
    cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h50; cpu_wdata = 32'h7777_7777; #1;
    check_eq("cedrop_cpu_we", {31'b0, mem_we}, 32'd1);
    check_eq("cedrop_cpu_addr", {22'b0, mem_addr}, 32'd20);
    step();
    cpu_en = 1'b0; cpu_we = 1'b0;
    check_eq("cedrop_mem12", mem[12], 32'h1111_2222);
    check_eq("cedrop_mem20", mem[20], 32'h7777_7777);
    check_eq("cedrop_we_count", 32'(n_we - n_we0), 32'd1);

    // re-enter debug, then write 0x1 (stuck bit 0 when verifying)
    dbg_ce = 1'b1;
    step(); step(); step();
    check_eq("reent_rdata", dbg_rdata, 32'h1111_2222);
`ifdef DEBUG_MEM_BRIDGE_WR_VERIFY_EN
    stuck0 = 1'b1;
`endif
    dbg_we = 1'b1; dbg_wdata = 32'h0000_0001;
    step();
    dbg_we = 1'b0;
    step(); step(); step();
`ifdef DEBUG_MEM_BRIDGE_WR_VERIFY_EN
    check_eq("vfy_err_set", {31'b0, wr_verify_err}, 32'd1);
    check_eq("vfy_rdata", dbg_rdata, 32'h0);
`else
    check_eq("vfy_err_set", {31'b0, wr_verify_err}, 32'd0);
    check_eq("vfy_rdata", dbg_rdata, 32'h1);
`endif
    stuck0 = 1'b0;
    dbg_ce = 1'b0;
    step();
`ifdef DEBUG_MEM_BRIDGE_WR_VERIFY_EN
    check_eq("vfy_err_sticky", {31'b0, wr_verify_err}, 32'd1);
`else
    check_eq("vfy_err_sticky", {31'b0, wr_verify_err}, 32'd0);
`endif
    dbg_ce = 1'b1;
    step();
    check_eq("vfy_err_clr", {31'b0, wr_verify_err}, 32'd0);
    step(); step();

    // reset in the middle of a debug write
    dbg_we = 1'b1; dbg_wdata = 32'h0000_0099;
    step();
    dbg_we = 1'b0; #1;
    check_eq("rstmid_mwe_pre", {31'b0, mem_we}, 32'd1);
    rst_n = 1'b0; #1;
    check_eq("rstmid_mwe", {31'b0, mem_we}, 32'd0);
    check_eq("rstmid_busy", {31'b0, dbg_busy}, 32'd0);
    check_eq("rstmid_rdata", dbg_rdata, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
